// File: rtl/vga_avn_pkg.sv
// Shared types for the VRAM Avalon arbiter: FSM states and requester port ids.
package vga_avn_pkg;

  typedef enum logic [1:0] {IDLE, HOLD1, HOLD2} arb_state_t;

  typedef enum logic {PORT1 = 1'b0, PORT2 = 1'b1} port_id_t;

endpackage

// File: rtl/vga_avn_rsp_fifo.sv
// Read-response routing FIFO: remembers which port issued each outstanding read.
module vga_avn_rsp_fifo
  import vga_avn_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  port_id_t                 i_push_id,
  input  logic                     i_pop,
  output port_id_t                 o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW:0] FULL_CNT = CW'(DEPTH);

  port_id_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so push-on-full is fine alongside it.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_avn_arbiter.sv
// Shares one VRAM Avalon slave between the pixel port (port1) and VGA prefetch port (port2),
// with lock-until-accept, urgency-boosted round robin and in-order read response routing.
module vga_avn_arbiter
  import vga_avn_pkg::*;
#(
  parameter int AVN_AW       = 18,
  parameter int AVN_DW       = 16,
  parameter int PENDING_READ = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,

  input  logic                          port1_avn_read,
  input  logic                          port1_avn_write,
  input  logic [AVN_AW-1:0]             port1_avn_address,
  input  logic [AVN_DW-1:0]             port1_avn_writedata,
  input  logic [AVN_DW/8-1:0]           port1_avn_byteenable,
  output logic [AVN_DW-1:0]             port1_avn_readdata,
  output logic                          port1_avn_readdatavalid,
  output logic                          port1_avn_waitrequest,

  input  logic                          port2_avn_read,
  input  logic                          port2_avn_write,
  input  logic [AVN_AW-1:0]             port2_avn_address,
  input  logic [AVN_DW-1:0]             port2_avn_writedata,
  input  logic [AVN_DW/8-1:0]           port2_avn_byteenable,
  output logic [AVN_DW-1:0]             port2_avn_readdata,
  output logic                          port2_avn_readdatavalid,
  output logic                          port2_avn_waitrequest,
  input  logic                          port2_urgent,

  output logic                          out_avn_read,
  output logic                          out_avn_write,
  output logic [AVN_AW-1:0]             out_avn_address,
  output logic [AVN_DW-1:0]             out_avn_writedata,
  output logic [AVN_DW/8-1:0]           out_avn_byteenable,
  input  logic [AVN_DW-1:0]             out_avn_readdata,
  input  logic                          out_avn_readdatavalid,
  input  logic                          out_avn_waitrequest,

  output logic [$clog2(PENDING_READ):0] pending_cnt,
  output logic                          rsp_err
);

  arb_state_t r_state;
  port_id_t   r_rr_last;
  logic       r_rsp_err;

  logic       w_fifo_full;
  logic       w_fifo_empty;
  port_id_t   w_fifo_head;
  logic       w_p1_elig;
  logic       w_p2_elig;
  logic       w_grant_valid;
  port_id_t   w_winner;
  logic       w_sel_read;
  logic       w_sel_write;
  logic       w_push;
  logic       w_rsp_hit;

  // Read+write together counts as a read; reads drop out while the route FIFO is full.
  always_comb begin
    w_p1_elig     = port1_avn_read ? ~w_fifo_full : port1_avn_write;
    w_p2_elig     = port2_avn_read ? ~w_fifo_full : port2_avn_write;
    w_winner      = PORT1;
    w_grant_valid = 1'b0;
    case (r_state)
      HOLD1: begin
        w_winner      = PORT1;
        w_grant_valid = sys_rst_n;
      end
      HOLD2: begin
        w_winner      = PORT2;
        w_grant_valid = sys_rst_n;
      end
      default: begin
        w_grant_valid = sys_rst_n & (w_p1_elig | w_p2_elig);
        if (w_p2_elig & port2_urgent)   w_winner = PORT2;
        else if (w_p1_elig & w_p2_elig) w_winner = (r_rr_last == PORT1) ? PORT2 : PORT1;
        else if (w_p2_elig)             w_winner = PORT2;
        else                            w_winner = PORT1;
      end
    endcase
  end

  always_comb begin
    if (w_winner == PORT2) begin
      w_sel_read         = port2_avn_read;
      w_sel_write        = port2_avn_write;
      out_avn_address    = port2_avn_address;
      out_avn_writedata  = port2_avn_writedata;
      out_avn_byteenable = port2_avn_byteenable;
    end else begin
      w_sel_read         = port1_avn_read;
      w_sel_write        = port1_avn_write;
      out_avn_address    = port1_avn_address;
      out_avn_writedata  = port1_avn_writedata;
      out_avn_byteenable = port1_avn_byteenable;
    end
    out_avn_read  = w_grant_valid & w_sel_read;
    out_avn_write = w_grant_valid & w_sel_write & ~w_sel_read;
  end

  assign port1_avn_waitrequest = ~(w_grant_valid & (w_winner == PORT1)) | out_avn_waitrequest;
  assign port2_avn_waitrequest = ~(w_grant_valid & (w_winner == PORT2)) | out_avn_waitrequest;

  assign w_push    = out_avn_read & ~out_avn_waitrequest;
  assign w_rsp_hit = sys_rst_n & out_avn_readdatavalid & ~w_fifo_empty;

  assign port1_avn_readdata      = out_avn_readdata;
  assign port2_avn_readdata      = out_avn_readdata;
  assign port1_avn_readdatavalid = w_rsp_hit & (w_fifo_head == PORT1);
  assign port2_avn_readdatavalid = w_rsp_hit & (w_fifo_head == PORT2);
  assign rsp_err                 = r_rsp_err;

  vga_avn_rsp_fifo #(
    .DEPTH (PENDING_READ)
  ) u_rsp_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .i_push    (w_push),
    .i_push_id (w_winner),
    .i_pop     (w_rsp_hit),
    .o_head    (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (pending_cnt)
  );

  // HOLD states reuse the grant logic: a waited grant locks, an accepted one releases.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= IDLE;
      r_rr_last <= PORT2;
      r_rsp_err <= 1'b0;
    end else begin
      if (out_avn_readdatavalid & w_fifo_empty) r_rsp_err <= 1'b1;
      if (w_grant_valid) begin
        if (out_avn_waitrequest) begin
          r_state <= (w_winner == PORT1) ? HOLD1 : HOLD2;
        end else begin
          r_state   <= IDLE;
          r_rr_last <= w_winner;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_avn_arbiter.sv
// Bench for vga_avn_arbiter: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_vga_avn_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int PR = 16;
  localparam int CW = $clog2(PR) + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [1:0]    p_rd, p_wr;
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  logic [BW-1:0] p_be    [2];
  logic          urgent;
  logic [DW-1:0] p1_rdata, p2_rdata;
  logic          p1_rdv, p2_rdv, p1_wait, p2_wait;
  logic          out_rd, out_wr;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_wdata;
  logic [BW-1:0] out_be;
  logic [DW-1:0] vram_rdata;
  logic          vram_rdv, vram_wait;
  logic [CW-1:0] pending;
  logic          err;

  always #5 sys_clk = ~sys_clk;

  vga_avn_arbiter #(.AVN_AW(AW), .AVN_DW(DW), .PENDING_READ(PR)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .port1_avn_read(p_rd[0]), .port1_avn_write(p_wr[0]), .port1_avn_address(p_addr[0]),
    .port1_avn_writedata(p_wdata[0]), .port1_avn_byteenable(p_be[0]),
    .port1_avn_readdata(p1_rdata), .port1_avn_readdatavalid(p1_rdv), .port1_avn_waitrequest(p1_wait),
    .port2_avn_read(p_rd[1]), .port2_avn_write(p_wr[1]), .port2_avn_address(p_addr[1]),
    .port2_avn_writedata(p_wdata[1]), .port2_avn_byteenable(p_be[1]),
    .port2_avn_readdata(p2_rdata), .port2_avn_readdatavalid(p2_rdv), .port2_avn_waitrequest(p2_wait),
    .port2_urgent(urgent),
    .out_avn_read(out_rd), .out_avn_write(out_wr), .out_avn_address(out_addr),
    .out_avn_writedata(out_wdata), .out_avn_byteenable(out_be),
    .out_avn_readdata(vram_rdata), .out_avn_readdatavalid(vram_rdv), .out_avn_waitrequest(vram_wait),
    .pending_cnt(pending), .rsp_err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: lock owner, last grant, outstanding read owners, sticky error.
  int            lock_m;
  int            rr_m;
  int            pend_q[$];
  bit            err_m;
  logic [AW-1:0] iss_q0[$];
  logic [AW-1:0] iss_q1[$];
  // VRAM model: in-order returns, data = address tag.
  logic [AW-1:0] ret_addr_q[$];
  int            ret_due_q[$];
  int            last_due;

  bit active [2];
  int wreq_mode, lat_min, lat_max, req_pct, rd_pct, ill_pct;
  bit vram_stall, inject_rdv, auto_req;
  int dut_grant;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_model();
    lock_m = -1;
    rr_m   = 1;
    err_m  = 1'b0;
    pend_q.delete();
    iss_q0.delete();
    iss_q1.delete();
    ret_addr_q.delete();
    ret_due_q.delete();
    last_due = 0;
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    active[p]  = 1'b1;
    p_rd[p]    = rd;
    p_wr[p]    = wr;
    p_addr[p]  = a;
    p_wdata[p] = d;
    p_be[p]    = BW'($urandom);
  endtask

  task automatic clear_req(input int p);
    active[p] = 1'b0;
    p_rd[p]   = 1'b0;
    p_wr[p]   = 1'b0;
  endtask

  // One clock cycle: drive, sample at negedge against the model, advance model at the edge.
  task automatic step();
    bit            e [2];
    bit            gv, rv, acc, r;
    int            win, hp, due;
    logic [AW-1:0] ea;
    if (auto_req) begin
      for (int p = 0; p < 2; p++) begin
        if (!active[p] && $urandom_range(99) < req_pct) begin
          r = ($urandom_range(99) < rd_pct);
          set_req(p, r, !r || ($urandom_range(99) < ill_pct), AW'($urandom), DW'($urandom));
        end
      end
    end
    case (wreq_mode)
      0:       vram_wait = 1'b0;
      1:       vram_wait = 1'b1;
      default: vram_wait = ($urandom_range(99) < 30);
    endcase
    vram_rdv   = 1'b0;
    vram_rdata = DW'($urandom);
    if (inject_rdv) begin
      vram_rdv   = 1'b1;
      vram_rdata = 16'hDEAD;
    end else if (!vram_stall && ret_due_q.size() > 0 && ret_due_q[0] <= cyc) begin
      ea         = ret_addr_q[0];
      vram_rdv   = 1'b1;
      vram_rdata = ea[DW-1:0];
      ret_due_q.delete(0);
      ret_addr_q.delete(0);
    end
    @(negedge sys_clk);
    for (int p = 0; p < 2; p++) e[p] = p_rd[p] ? (pend_q.size() < PR) : p_wr[p];
    gv  = 1'b0;
    win = 0;
    if (sys_rst_n) begin
      if (lock_m >= 0)          begin gv = 1'b1; win = lock_m; end
      else if (e[1] && urgent)  begin gv = 1'b1; win = 1; end
      else if (e[0] && e[1])    begin gv = 1'b1; win = (rr_m == 0) ? 1 : 0; end
      else if (e[0] || e[1])    begin gv = 1'b1; win = e[0] ? 0 : 1; end
    end
    check_val("out_read", out_rd, gv && p_rd[win]);
    check_val("out_write", out_wr, gv && p_wr[win] && !p_rd[win]);
    if (gv) begin
      check_val("out_addr", out_addr, p_addr[win]);
      check_val("out_wdata", out_wdata, p_wdata[win]);
      check_val("out_be", out_be, p_be[win]);
    end
    check_val("p1_wait", p1_wait, (gv && win == 0) ? vram_wait : 1'b1);
    check_val("p2_wait", p2_wait, (gv && win == 1) ? vram_wait : 1'b1);
    rv = sys_rst_n && vram_rdv && pend_q.size() > 0;
    hp = rv ? pend_q[0] : -1;
    check_val("p1_rdv", p1_rdv, hp == 0);
    check_val("p2_rdv", p2_rdv, hp == 1);
    if (hp == 0) begin ea = iss_q0[0]; check_val("p1_rdata", p1_rdata, ea[DW-1:0]); end
    if (hp == 1) begin ea = iss_q1[0]; check_val("p2_rdata", p2_rdata, ea[DW-1:0]); end
    check_val("pending", pending, pend_q.size());
    check_val("rsp_err", err, err_m);
    dut_grant = !p1_wait ? 0 : (!p2_wait ? 1 : -1);
    acc = gv && !vram_wait;
    if (!sys_rst_n) begin
      reset_model();
    end else begin
      if (rv) begin
        if (hp == 0) iss_q0.delete(0); else iss_q1.delete(0);
        pend_q.delete(0);
      end else if (vram_rdv) begin
        err_m = 1'b1;
      end
      if (gv && vram_wait) lock_m = win;
      if (acc) begin
        lock_m = -1;
        rr_m   = win;
        $display("ACC cyc=%0d port=%0d %s addr=%05h", cyc, win + 1, p_rd[win] ? "RD" : "WR", p_addr[win]);
        if (p_rd[win]) begin
          pend_q.push_back(win);
          if (win == 0) iss_q0.push_back(p_addr[win]); else iss_q1.push_back(p_addr[win]);
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          ret_due_q.push_back(due);
          ret_addr_q.push_back(p_addr[win]);
        end
      end
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    if (acc) clear_req(win);
  endtask

  task automatic drain();
    auto_req   = 1'b0;
    wreq_mode  = 0;
    vram_stall = 1'b0;
    inject_rdv = 1'b0;
    urgent     = 1'b0;
    for (int i = 0; i < 100 && (active[0] || active[1] || pend_q.size() > 0); i++) step();
    check_val("drain_pending", pending, 0);
  endtask

  int g [8];

  initial begin
    sys_rst_n = 1'b0;
    p_rd = '0; p_wr = '0; urgent = 1'b0;
    for (int p = 0; p < 2; p++) begin
      p_addr[p] = '0; p_wdata[p] = '0; p_be[p] = '0; active[p] = 1'b0;
    end
    vram_rdata = '0; vram_rdv = 1'b0; vram_wait = 1'b0;
    wreq_mode = 0; lat_min = 2; lat_max = 2; req_pct = 100; rd_pct = 100; ill_pct = 0;
    vram_stall = 1'b0; inject_rdv = 1'b0; auto_req = 1'b0; dut_grant = -1;
    reset_model();
    @(posedge sys_clk);
    #1;
    // Requests during reset must stay blocked.
    set_req(0, 1'b1, 1'b0, 18'h00123, 16'h0);
    repeat (2) step();
    clear_req(0);
    sys_rst_n = 1'b1;
    step();

    // Single port1 write.
    set_req(0, 1'b0, 1'b1, 18'h00010, 16'hABCD);
    step();
    check_val("t1_grant", dut_grant, 0);
    step();

    // Continuous reads from both ports alternate (rr_last is port1 after the write).
    auto_req = 1'b1; req_pct = 100; rd_pct = 100; ill_pct = 0; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 8; i++) begin step(); g[i] = dut_grant; end
    for (int i = 0; i < 8; i++) check_val("t2_grant", g[i], (i + 1) % 2);
    drain();

    // port2 read locked through 3 waited cycles while port1 requests and urgent toggles.
    urgent = 1'b1; wreq_mode = 1;
    set_req(1, 1'b1, 1'b0, 18'h20040, 16'h0);
    step();
    set_req(0, 1'b0, 1'b1, 18'h00777, 16'h1234);
    for (int i = 0; i < 2; i++) begin
      urgent = ~urgent;
      step();
      check_val("t3_addr", out_addr, 18'h20040);
      check_val("t3_p1_wait", p1_wait, 1'b1);
    end
    wreq_mode = 0;
    step();
    check_val("t3_accept", dut_grant, 1);
    drain();

    // Fill the route FIFO, then stall the 17th read while a write still passes.
    vram_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_req(0, 1'b1, 1'b0, AW'(32'h3000 + i), 16'h0);
      step();
      check_val("t4_acc", dut_grant, 0);
    end
    check_val("t4_pending16", pending, 16);
    set_req(0, 1'b1, 1'b0, 18'h03100, 16'h0);
    step();
    check_val("t4_stall", dut_grant, -1);
    set_req(1, 1'b0, 1'b1, 18'h03200, 16'h5555);
    step();
    check_val("t4_p2_write", dut_grant, 1);
    vram_stall = 1'b0;
    step();
    check_val("t4_rsp_cycle", dut_grant, -1);
    step();
    check_val("t4_17th", dut_grant, 0);
    drain();

    // Urgent tie for 4 cycles, then round robin resumes with port1.
    auto_req = 1'b1; req_pct = 100; rd_pct = 0; urgent = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); g[i] = dut_grant; end
    urgent = 1'b0;
    for (int i = 4; i < 6; i++) begin step(); g[i] = dut_grant; end
    for (int i = 0; i < 4; i++) check_val("t5_urgent", g[i], 1);
    check_val("t5_rr1", g[4], 0);
    check_val("t5_rr2", g[5], 1);
    drain();

    // Spurious response with an empty FIFO.
    inject_rdv = 1'b1;
    step();
    inject_rdv = 1'b0;
    step();
    check_val("t6_err", err, 1'b1);

    // Reset with 5 reads outstanding; a late response then hits an empty FIFO.
    vram_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, 1'b0, AW'(32'h4000 + i), 16'h0);
      step();
    end
    check_val("t7_pending5", pending, 5);
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    vram_stall = 1'b0;
    check_val("t7_pending0", pending, 0);
    check_val("t7_err0", err, 1'b0);
    check_val("t7_p1_wait", p1_wait, 1'b1);
    check_val("t7_p2_wait", p2_wait, 1'b1);
    inject_rdv = 1'b1;
    step();
    inject_rdv = 1'b0;
    step();
    check_val("t7_late_err", err, 1'b1);

    // Randomized traffic.
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    auto_req = 1'b1; req_pct = 60; rd_pct = 60; ill_pct = 10;
    wreq_mode = 2; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      urgent = ($urandom_range(99) < 20);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
